// File: rtl/page_table_walker_pkg.sv
// rtl/page_table_walker_pkg.sv - shared PTE layout, walker states and fault codes
package page_table_walker_pkg;

    // Flag bit positions inside a 32-bit PTE
    localparam int PTE_V_BIT = 0;
    localparam int PTE_R_BIT = 1;
    localparam int PTE_W_BIT = 2;
    localparam int PTE_X_BIT = 3;

    // Fault codes, also consumed by the TLB and the fault handler
    localparam logic [1:0] FAULT_NONE       = 2'd0;
    localparam logic [1:0] FAULT_INVALID    = 2'd1;
    localparam logic [1:0] FAULT_MISALIGNED = 2'd2;
    localparam logic [1:0] FAULT_NONLEAF    = 2'd3;

    typedef struct packed {
        logic [19:0] ppn;
        logic [7:0]  rsvd;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1_REQ,
        ST_L1_WAIT,
        ST_L0_REQ,
        ST_L0_WAIT,
        ST_DONE,
        ST_FAULT,
        ST_DRAIN
    } walk_state_e;

endpackage

// File: rtl/page_table_walker_if.sv
// rtl/page_table_walker_if.sv - miss, PTE memory and TLB-fill signal bundle
interface page_table_walker_if;
    logic        miss_valid;
    logic [31:0] miss_vaddr;
    logic        miss_ready;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        upd_valid;
    logic [31:0] upd_vaddr;
    logic [31:0] upd_paddr;
    logic        fault_valid;
    logic [1:0]  fault_code;

    modport master (
        input  miss_valid, miss_vaddr, mem_req_ready, mem_resp_valid, mem_resp_data,
        output miss_ready, mem_req_valid, mem_req_addr,
        output upd_valid, upd_vaddr, upd_paddr, fault_valid, fault_code
    );

    modport slave (
        output miss_valid, miss_vaddr, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  miss_ready, mem_req_valid, mem_req_addr,
        input  upd_valid, upd_vaddr, upd_paddr, fault_valid, fault_code
    );
endinterface

// File: rtl/page_table_walker_pte_check.sv
// rtl/page_table_walker_pte_check.sv - PTE decode: leaf, fault classification, next PPN
module page_table_walker_pte_check
    import page_table_walker_pkg::*;
(
    input  pte_t        pte_i,
    input  logic        level1_i,
    input  logic [9:0]  vpn0_i,
    output logic        leaf_o,
    output logic        fault_o,
    output logic [1:0]  fault_code_o,
    output logic [19:0] next_ppn_o
);

    logic leaf;
    logic invalid;
    logic unused_rsvd;

    assign unused_rsvd = ^pte_i.rsvd;

    // Classify the PTE; a superpage leaf splices VPN0 into the low PPN bits
    always_comb begin
        leaf         = pte_i[PTE_R_BIT] | pte_i[PTE_W_BIT] | pte_i[PTE_X_BIT];
        invalid      = !pte_i[PTE_V_BIT] || (pte_i[PTE_W_BIT] && !pte_i[PTE_R_BIT]);
        leaf_o       = leaf;
        fault_o      = 1'b0;
        fault_code_o = FAULT_NONE;
        next_ppn_o   = pte_i.ppn;
        if (invalid) begin
            fault_o      = 1'b1;
            fault_code_o = FAULT_INVALID;
        end else if (level1_i && leaf && (pte_i.ppn[9:0] != 10'd0)) begin
            fault_o      = 1'b1;
            fault_code_o = FAULT_MISALIGNED;
        end else if (!level1_i && !leaf) begin
            fault_o      = 1'b1;
            fault_code_o = FAULT_NONLEAF;
        end
        if (level1_i && leaf) begin
            next_ppn_o = {pte_i.ppn[19:10], vpn0_i};
        end
    end

endmodule

// File: rtl/page_table_walker.sv
// rtl/page_table_walker.sv - two-level page-table walker producing TLB fills and faults
module page_table_walker
    import page_table_walker_pkg::*;
#(
    parameter int PTBR_W = 20,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PTBR_W-1:0]   ptbr_i,
    input  logic                abort_i,
    page_table_walker_if.master bus,
    output logic [CNT_W-1:0]    walk_count_o,
    output logic [CNT_W-1:0]    fault_count_o
);

    walk_state_e       state_q, state_d;
    logic [31:0]       vaddr_q, vaddr_d;
    logic [PTBR_W-1:0] ptbr_q, ptbr_d;
    logic [19:0]       ppn1_q, ppn1_d;
    logic [31:0]       upd_vaddr_q, upd_vaddr_d;
    logic [31:0]       upd_paddr_q, upd_paddr_d;
    logic [1:0]        fault_code_q, fault_code_d;
    logic [CNT_W-1:0]  walk_cnt_q, walk_cnt_d;
    logic [CNT_W-1:0]  fault_cnt_q, fault_cnt_d;

    logic        miss_ready, req_valid, upd_valid, fault_valid;
    logic [31:0] req_addr, l1_addr, l0_addr;
    logic        chk_leaf, chk_fault;
    logic [1:0]  chk_code;
    logic [19:0] chk_ppn;

    assign l1_addr = 32'({ptbr_q, vaddr_q[31:22], 2'b00});
    assign l0_addr = {ppn1_q, vaddr_q[21:12], 2'b00};

    page_table_walker_pte_check u_pte_check (
        .pte_i        (pte_t'(bus.mem_resp_data)),
        .level1_i     (state_q == ST_L1_WAIT),
        .vpn0_i       (vaddr_q[21:12]),
        .leaf_o       (chk_leaf),
        .fault_o      (chk_fault),
        .fault_code_o (chk_code),
        .next_ppn_o   (chk_ppn)
    );

    // Walk FSM: next state, latched walk context, result registers and strobes
    always_comb begin
        state_d      = state_q;
        vaddr_d      = vaddr_q;
        ptbr_d       = ptbr_q;
        ppn1_d       = ppn1_q;
        upd_vaddr_d  = upd_vaddr_q;
        upd_paddr_d  = upd_paddr_q;
        fault_code_d = fault_code_q;
        walk_cnt_d   = walk_cnt_q;
        fault_cnt_d  = fault_cnt_q;
        miss_ready   = 1'b0;
        req_valid    = 1'b0;
        req_addr     = 32'h0;
        upd_valid    = 1'b0;
        fault_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                miss_ready = 1'b1;
                if (bus.miss_valid) begin
                    vaddr_d = bus.miss_vaddr;
                    ptbr_d  = ptbr_i;
                    state_d = ST_L1_REQ;
                end
            end
            ST_L1_REQ, ST_L0_REQ: begin
                // An abort suppresses the request, so nothing is outstanding
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    req_valid = 1'b1;
                    req_addr  = (state_q == ST_L1_REQ) ? l1_addr : l0_addr;
                    if (bus.mem_req_ready) begin
                        state_d = (state_q == ST_L1_REQ) ? ST_L1_WAIT : ST_L0_WAIT;
                    end
                end
            end
            ST_L1_WAIT, ST_L0_WAIT: begin
                // A response arriving with the abort is already consumed
                if (abort_i) begin
                    state_d = bus.mem_resp_valid ? ST_IDLE : ST_DRAIN;
                end else if (bus.mem_resp_valid) begin
                    if (chk_fault) begin
                        fault_code_d = chk_code;
                        state_d      = ST_FAULT;
                    end else if (chk_leaf) begin
                        upd_vaddr_d = vaddr_q;
                        upd_paddr_d = {chk_ppn, 12'h000};
                        state_d     = ST_DONE;
                    end else begin
                        ppn1_d  = chk_ppn;
                        state_d = ST_L0_REQ;
                    end
                end
            end
            ST_DONE: begin
                upd_valid = 1'b1;
                if (walk_cnt_q != '1) walk_cnt_d = walk_cnt_q + CNT_W'(1);
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                fault_valid = 1'b1;
                if (fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + CNT_W'(1);
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (bus.mem_resp_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            vaddr_q      <= '0;
            ptbr_q       <= '0;
            ppn1_q       <= '0;
            upd_vaddr_q  <= '0;
            upd_paddr_q  <= '0;
            fault_code_q <= FAULT_NONE;
            walk_cnt_q   <= '0;
            fault_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            vaddr_q      <= vaddr_d;
            ptbr_q       <= ptbr_d;
            ppn1_q       <= ppn1_d;
            upd_vaddr_q  <= upd_vaddr_d;
            upd_paddr_q  <= upd_paddr_d;
            fault_code_q <= fault_code_d;
            walk_cnt_q   <= walk_cnt_d;
            fault_cnt_q  <= fault_cnt_d;
        end
    end

    assign bus.miss_ready    = miss_ready;
    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = req_addr;
    assign bus.upd_valid     = upd_valid;
    assign bus.upd_vaddr     = upd_vaddr_q;
    assign bus.upd_paddr     = upd_paddr_q;
    assign bus.fault_valid   = fault_valid;
    assign bus.fault_code    = fault_code_q;
    assign walk_count_o      = walk_cnt_q;
    assign fault_count_o     = fault_cnt_q;

endmodule

// File: tb/tb_page_table_walker.sv
// tb/tb_page_table_walker.sv - randomized self-checking bench for page_table_walker
module tb_page_table_walker;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] ptbr;
    logic        abort;
    logic [15:0] walk_count, fault_count;

    page_table_walker_if bus ();

    page_table_walker #(.PTBR_W(20), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .ptbr_i        (ptbr),
        .abort_i       (abort),
        .bus           (bus),
        .walk_count_o  (walk_count),
        .fault_count_o (fault_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] req_q [$];
    int          n_upd, n_fault, t_res, t_ready, t_resp, stab_err;
    logic [31:0] got_paddr, got_vaddr;
    logic [1:0]  got_code;
    int          m_walks, m_faults;
    int          e_kind, e_nreq;
    logic [31:0] e_paddr, e_a1, e_a0;
    logic [1:0]  e_code;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Reference walk straight from the page-table rules: kind 1 = fill, 2 = fault
    task automatic model(input logic [19:0] p, input logic [31:0] va);
        logic [31:0] e1, e0;
        e_a1 = {p, va[31:22], 2'b00};
        e1 = rd(e_a1);
        e_nreq = 1; e_a0 = 32'h0; e_paddr = 32'h0; e_code = 2'd0; e_kind = 2;
        if (!e1[0] || (e1[2] && !e1[1])) e_code = 2'd1;
        else if (e1[3:1] != 3'b000) begin
            if (e1[21:12] != 10'd0) e_code = 2'd2;
            else begin e_kind = 1; e_paddr = {e1[31:22], va[21:12], 12'h000}; end
        end else begin
            e_nreq = 2;
            e_a0 = {e1[31:12], va[21:12], 2'b00};
            e0 = rd(e_a0);
            if (!e0[0] || (e0[2] && !e0[1])) e_code = 2'd1;
            else if (e0[3:1] == 3'b000) e_code = 2'd3;
            else begin e_kind = 1; e_paddr = {e0[31:12], 12'h000}; end
        end
    endtask

    function automatic logic [31:0] rand_pte(input int kind);
        logic [31:0] e;
        e = $urandom;
        case (kind)
            0: if ($urandom_range(0, 1) == 1) e[0] = 1'b0;
               else begin e[0] = 1'b1; e[1] = 1'b0; e[2] = 1'b1; end
            1: e[3:0] = 4'b0001;
            default: begin
                e[1:0] = 2'b11;
                if ($urandom_range(0, 1) == 1) e[21:12] = 10'd0;
            end
        endcase
        return e;
    endfunction

    // Issue one miss and act as the PTE memory until the walker is idle again
    task automatic run_walk(input logic [19:0] p, input logic [31:0] va, input int rdy_dly,
                            input int rsp_dly, input int abort_at, input int reset_at);
        int t, stall, resp_at;
        bit prev_pend, done;
        logic [31:0] prev_addr, pend_addr;
        n_upd = 0; n_fault = 0; t_res = -1; t_ready = -1; t_resp = -1; stab_err = 0;
        req_q.delete();
        ptbr = p; bus.miss_vaddr = va; bus.miss_valid = 1'b1;
        @(posedge clk); #1;
        bus.miss_valid = 1'b0;
        t = 1; stall = 0; resp_at = -1; prev_pend = 0; done = 0;
        prev_addr = 32'h0; pend_addr = 32'h0;
        while (!done && t < 80) begin
            abort = (t == abort_at);
            reset = (t == reset_at);
            bus.mem_resp_valid = (t == resp_at);
            bus.mem_resp_data  = (t == resp_at) ? rd(pend_addr) : 32'h0;
            if (t == resp_at) t_resp = t;
            #1;
            if (bus.upd_valid) begin
                n_upd++; t_res = t; got_paddr = bus.upd_paddr; got_vaddr = bus.upd_vaddr;
            end
            if (bus.fault_valid) begin
                n_fault++; t_res = t; got_code = bus.fault_code;
            end
            if (prev_pend && !abort && (!bus.mem_req_valid || bus.mem_req_addr != prev_addr))
                stab_err++;
            bus.mem_req_ready = 1'b0;
            prev_pend = 0;
            if (bus.mem_req_valid) begin
                if (stall >= rdy_dly) begin
                    bus.mem_req_ready = 1'b1;
                    req_q.push_back(bus.mem_req_addr);
                    pend_addr = bus.mem_req_addr;
                    resp_at = t + 1 + rsp_dly;
                    stall = 0;
                end else begin
                    stall++; prev_pend = 1; prev_addr = bus.mem_req_addr;
                end
            end
            if (bus.miss_ready) begin
                t_ready = t; done = 1;
            end else begin
                @(posedge clk); #1;
                t++;
            end
        end
        if (!done) chk("walk_timeout", 0, 1);
        abort = 1'b0; reset = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 32'h0;
    endtask

    task automatic do_walk(input string tag, input logic [19:0] p, input logic [31:0] va,
                           input int rdy, input int rsp);
        model(p, va);
        run_walk(p, va, rdy, rsp, -1, -1);
        chk({tag, "_nreq"}, req_q.size(), e_nreq);
        if (req_q.size() > 0) chk({tag, "_addr1"}, req_q[0], e_a1);
        if (e_nreq == 2 && req_q.size() > 1) chk({tag, "_addr0"}, req_q[1], e_a0);
        chk({tag, "_stable"}, stab_err, 0);
        chk({tag, "_latency"}, t_res, 1 + e_nreq * (2 + rdy + rsp));
        if (e_kind == 1) begin
            if (m_walks != 16'hFFFF) m_walks++;
            chk({tag, "_upd_n"}, n_upd, 1);
            chk({tag, "_fault_n"}, n_fault, 0);
            chk({tag, "_paddr"}, got_paddr, e_paddr);
            chk({tag, "_vaddr"}, got_vaddr, va);
        end else begin
            if (m_faults != 16'hFFFF) m_faults++;
            chk({tag, "_fault_n"}, n_fault, 1);
            chk({tag, "_upd_n"}, n_upd, 0);
            chk({tag, "_code"}, got_code, e_code);
        end
        chk({tag, "_walk_count"}, walk_count, m_walks);
        chk({tag, "_fault_count"}, fault_count, m_faults);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_miss_ready"}, bus.miss_ready, 1);
        chk({tag, "_req_valid"}, bus.mem_req_valid, 0);
        chk({tag, "_req_addr"}, bus.mem_req_addr, 0);
        chk({tag, "_upd_valid"}, bus.upd_valid, 0);
        chk({tag, "_upd_vaddr"}, bus.upd_vaddr, 0);
        chk({tag, "_upd_paddr"}, bus.upd_paddr, 0);
        chk({tag, "_fault_valid"}, bus.fault_valid, 0);
        chk({tag, "_fault_code"}, bus.fault_code, 0);
        chk({tag, "_walk_count"}, walk_count, 0);
        chk({tag, "_fault_count"}, fault_count, 0);
    endtask

    localparam logic [31:0] VA = 32'h00403ABC;

    initial begin
        reset = 1'b1; abort = 1'b0; ptbr = 20'h0;
        bus.miss_valid = 1'b0; bus.miss_vaddr = 32'h0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 32'h0;
        m_walks = 0; m_faults = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_idle_zero("reset");

        mem[32'h00010004] = 32'h00020001;
        mem[32'h0002000C] = 32'h1234500B;
        do_walk("walk4k", 20'h00010, VA, 0, 0);
        chk("walk4k_paddr_const", got_paddr, 32'h12345000);

        mem[32'h00010004] = 32'h12C00003;
        do_walk("super", 20'h00010, VA, 0, 0);
        chk("super_paddr_const", got_paddr, 32'h12C03000);

        mem[32'h00010004] = 32'h00000000;
        do_walk("fault_inv", 20'h00010, VA, 0, 0);
        mem[32'h00010004] = 32'h12C01003;
        do_walk("fault_mis", 20'h00010, VA, 0, 0);
        mem[32'h00010004] = 32'h00020001;
        mem[32'h0002000C] = 32'h00030001;
        do_walk("fault_nl", 20'h00010, VA, 0, 0);
        chk("fault_nl_code_const", got_code, 2'd3);
        chk("three_faults", fault_count, 3);
        chk("fault_code_hold", bus.fault_code, 2'd3);

        mem[32'h00010004] = 32'h12C00003;
        do_walk("backpressure", 20'h00010, VA, 4, 0);
        chk("backpressure_t", t_res, 7);

        mem[32'h00010004] = 32'h00020001;
        mem[32'h0002000C] = 32'h1234500B;
        run_walk(20'h00010, VA, 0, 3, 2, -1);
        chk("abort_wait_upd", n_upd, 0);
        chk("abort_wait_fault", n_fault, 0);
        chk("abort_wait_nreq", req_q.size(), 1);
        chk("abort_wait_ready_t", t_ready, 6);
        chk("abort_wait_walks", walk_count, m_walks);
        do_walk("after_abort", 20'h00010, VA, 0, 0);

        run_walk(20'h00010, VA, 3, 0, 1, -1);
        chk("abort_req_nreq", req_q.size(), 0);
        chk("abort_req_ready_t", t_ready, 2);
        chk("abort_req_pulses", n_upd + n_fault, 0);

        for (int i = 0; i < 40; i++) begin
            logic [19:0] p;
            logic [31:0] va, a1, pte1;
            p = 20'($urandom);
            va = $urandom;
            a1 = {p, va[31:22], 2'b00};
            pte1 = rand_pte($urandom_range(0, 2));
            mem[a1] = pte1;
            if (pte1[3:0] == 4'b0001)
                mem[{pte1[31:12], va[21:12], 2'b00}] = rand_pte($urandom_range(0, 2));
            do_walk("rand", p, va, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        mem[32'h00010004] = 32'h00020001;
        mem[32'h0002000C] = 32'h1234500B;
        run_walk(20'h00010, VA, 0, 0, -1, 4);
        chk("reset_l0_upd", n_upd, 0);
        chk_idle_zero("reset_l0");
        m_walks = 0; m_faults = 0;
        do_walk("post_reset", 20'h00010, VA, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
